// File: rtl/vm1_bus_unit_pkg.sv
// Shared definitions for the VM1 bus cycle sequencer: FSM state encodings,
// byte-lane constants, the bus-error trap vector and lane/data helpers.
package vm1_bus_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CYCLE = 2'd1,
        ST_ERR   = 2'd2
    } bus_state_t;

    localparam logic [1:0]  LANE_LO = 2'b01;
    localparam logic [1:0]  LANE_HI = 2'b10;
    localparam logic [1:0]  LANE_W  = 2'b11;

    // Trap vector the microcode jumps to when buserr is reported.
    localparam logic [15:0] BUSERR_VECTOR = 16'o000004;

    // Byte lanes for an access: odd byte address selects the high lane.
    function automatic logic [1:0] lane_sel(input logic is_byte, input logic a0);
        if (!is_byte)
            return LANE_W;
        return a0 ? LANE_HI : LANE_LO;
    endfunction

    // Byte writes replicate the low byte so either lane carries it.
    function automatic logic [15:0] write_data(input logic is_byte, input logic [15:0] wdata);
        return is_byte ? {wdata[7:0], wdata[7:0]} : wdata;
    endfunction

    // Byte reads return the addressed lane zero-extended into the low byte.
    function automatic logic [15:0] read_data(input logic [1:0] sel, input logic [15:0] rdata);
        case (sel)
            LANE_HI: return {8'h00, rdata[15:8]};
            LANE_LO: return {8'h00, rdata[7:0]};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/vm1_bus_unit_if.sv
// External 16-bit memory/IO bus: strobe/ack cycle with byte-lane selects.
interface vm1_bus_unit_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [1:0]  sel;
    logic        we;
    logic        stb;
    logic        ack;

    modport master (output addr, wdata, sel, we, stb, input ack, rdata);
    modport slave  (input addr, wdata, sel, we, stb, output ack, rdata);
endinterface

// File: rtl/vm1_bus_unit_timer.sv
// Bus no-reply timer: up-counter with clear, enable and terminal count
// at TIMEOUT-1, so a strobe is held for exactly TIMEOUT enabled cycles.
module vm1_bus_unit_timer #(
    parameter int TIMEOUT = 64,
    parameter int TMO_W   = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TMO_W-1:0] count;

    // Count strobe cycles; clear has priority and nothing moves without ce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (ce) begin
            if (clr)
                count <= '0;
            else if (en)
                count <= count + 1'b1;
        end
    end

    assign tc = (count == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/vm1_bus_unit.sv
// VM1 bus cycle sequencer: takes one read/write request at a time from the
// datapath, runs a strobe/ack cycle on the external bus and reports done or
// buserr (odd word address, no-reply timeout) as one-cycle pulses.
module vm1_bus_unit
    import vm1_bus_unit_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TMO_W   = 7
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce,
    input  logic           req_rd,
    input  logic           req_wr,
    input  logic           req_byte,
    input  logic [15:0]    cpu_addr,
    input  logic [15:0]    cpu_wdata,
    output logic [15:0]    cpu_rdata,
    output logic           busy,
    output logic           done,
    output logic           buserr,
    vm1_bus_unit_if.master bus
);

    bus_state_t state;
    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_tc;

    // The timer only runs while a strobe is out; any other state resets it.
    assign tmr_en  = (state == ST_CYCLE);
    assign tmr_clr = (state != ST_CYCLE);

    vm1_bus_unit_timer #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .tc      (tmr_tc)
    );

    // Sequencer FSM with registered bus and datapath outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cpu_rdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            buserr    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            bus.sel   <= '0;
            bus.we    <= 1'b0;
            bus.stb   <= 1'b0;
        end else if (ce) begin
            done   <= 1'b0;
            buserr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_rd || req_wr) begin
                        if (!req_byte && cpu_addr[0]) begin
                            // Misaligned word: fault without touching the bus.
                            state <= ST_ERR;
                        end else begin
                            bus.addr  <= {cpu_addr[15:1], 1'b0};
                            bus.wdata <= write_data(req_byte, cpu_wdata);
                            bus.sel   <= lane_sel(req_byte, cpu_addr[0]);
                            bus.we    <= req_wr & ~req_rd;
                            bus.stb   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_CYCLE;
                        end
                    end
                end
                ST_CYCLE: begin
                    if (bus.ack) begin
                        // Ack wins over a coincident timeout.
                        cpu_rdata <= bus.we ? cpu_rdata : read_data(bus.sel, bus.rdata);
                        bus.stb   <= 1'b0;
                        bus.we    <= 1'b0;
                        bus.sel   <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (tmr_tc) begin
                        bus.stb   <= 1'b0;
                        bus.we    <= 1'b0;
                        bus.sel   <= '0;
                        busy      <= 1'b0;
                        state     <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    buserr <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vm1_bus_unit.sv
// Randomized and directed bench for vm1_bus_unit against a transaction-level model.
module tb_vm1_bus_unit;
    localparam int TIMEOUT = 64;
    localparam int TMO_W   = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic        req_rd = 1'b0, req_wr = 1'b0, req_byte = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        busy, done, buserr;

    vm1_bus_unit_if bus ();

    vm1_bus_unit #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_byte  (req_byte),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .busy      (busy),
        .done      (done),
        .buserr    (buserr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One request from the datapath plus the slave's reply behaviour.
    task automatic run_txn(input bit rd, input bit wr, input bit byt,
                           input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] rdv, input int wait_n,
                           input bit noack, input int ce_gap);
        logic [15:0] e_addr, e_wdata, e_rdata;
        logic [1:0]  e_sel;
        int n, frozen, k;
        @(negedge clk);
        req_rd = rd; req_wr = wr; req_byte = byt; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk); #1;
        req_rd = 0; req_wr = 0;
        if (!byt && a[0]) begin
            @(negedge clk);
            chk("odd_stb", bus.stb, 0);
            chk("odd_err_early", buserr, 0);
            @(negedge clk);
            chk("odd_err", buserr, 1);
            chk("odd_done", done, 0);
            chk("odd_stb2", bus.stb, 0);
            @(negedge clk);
            chk("odd_err_end", buserr, 0);
            chk("odd_rdata", cpu_rdata, last_rdata);
            return;
        end
        e_addr  = a - (a % 2);
        e_sel   = byt ? ((a % 2) ? 2'd2 : 2'd1) : 2'd3;
        e_wdata = byt ? (wd % 256) * 257 : wd;
        e_rdata = byt ? ((a % 2) ? rdv / 256 : rdv % 256) : rdv;
        @(negedge clk);
        chk("addr", bus.addr, e_addr);
        chk("sel", bus.sel, e_sel);
        chk("we", bus.we, (wr && !rd));
        chk("busy", busy, 1);
        if (wr && !rd) chk("wdata", bus.wdata, e_wdata);
        n = 0; frozen = 0;
        while (bus.stb === 1'b1 && n < TIMEOUT + ce_gap + 20) begin
            n++;
            if (ce_gap > 0 && n == 2) ce = 0;
            else if (ce == 0) begin
                frozen++;
                if (frozen == ce_gap) ce = 1;
            end
            if (ce == 0) chk("ce_frozen_stb", bus.stb, 1);
            if (!noack && n == wait_n + 1) begin
                bus.ack = 1; bus.rdata = rdv;
            end
            @(posedge clk); #1;
            bus.ack = 0; bus.rdata = 16'($urandom);
            @(negedge clk);
        end
        ce = 1;
        chk("stb_cycles", n, noack ? TIMEOUT + ce_gap : wait_n + 1);
        if (!noack) begin
            if (rd) last_rdata = e_rdata;
            chk("done", done, 1);
            chk("done_err", buserr, 0);
            chk("done_busy", busy, 0);
            chk("done_we", bus.we, 0);
            chk("rdata", cpu_rdata, last_rdata);
            @(negedge clk);
            chk("done_pulse", done, 0);
        end else begin
            k = 0;
            while (buserr !== 1'b1 && k < 4) begin
                chk("tmo_done", done, 0);
                @(negedge clk);
                k++;
            end
            chk("tmo_err", buserr, 1);
            chk("tmo_busy", busy, 0);
            @(negedge clk);
            chk("tmo_err_pulse", buserr, 0);
            chk("tmo_rdata", cpu_rdata, last_rdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ack = 0; bus.rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_ctl", {bus.we, bus.stb, busy, done, buserr}, 0);
        reset_n = 1;

        // Directed scenarios.
        run_txn(1, 0, 0, 16'o001000, 16'h0, 16'o123456, 3, 0, 0);
        chk("t1_rdata", cpu_rdata, 16'o123456);
        run_txn(0, 1, 1, 16'o177565, 16'h0041, 16'h0, 1, 0, 0);
        run_txn(1, 0, 0, 16'o001001, 16'h0, 16'h0, 0, 0, 0);
        run_txn(1, 0, 0, 16'o002000, 16'h0, 16'h0, 0, 1, 0);
        run_txn(1, 0, 0, 16'o002002, 16'h0, 16'h1234, 0, 0, 0);
        run_txn(1, 0, 1, 16'o000401, 16'h0, 16'hA55A, 2, 0, 0);
        chk("t5_hi", cpu_rdata, 16'h00A5);
        run_txn(1, 0, 1, 16'o000400, 16'h0, 16'hA55A, 0, 0, 0);
        chk("t5_lo", cpu_rdata, 16'h005A);
        run_txn(1, 0, 0, 16'o003000, 16'h0, 16'h0, 0, 1, 10);
        run_txn(1, 1, 0, 16'o004000, 16'hBEEF, 16'hCAFE, 1, 0, 0);

        // Ack while idle must not complete anything.
        @(negedge clk); bus.ack = 1;
        @(posedge clk); #1; bus.ack = 0;
        @(negedge clk);
        chk("idle_ack_done", done, 0);
        chk("idle_ack_stb", bus.stb, 0);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            bit rd, wr;
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            run_txn(rd, wr, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(0, 5), ($urandom_range(0, 7) == 0), 0);
        end

        // Asynchronous reset during a write cycle.
        @(negedge clk);
        req_wr = 1; req_byte = 0; cpu_addr = 16'o005000; cpu_wdata = 16'h1111;
        @(posedge clk); #1; req_wr = 0;
        @(negedge clk);
        chk("pre_rst_stb", bus.stb, 1);
        chk("pre_rst_we", bus.we, 1);
        #2 reset_n = 0;
        #1;
        chk("async_stb", bus.stb, 0);
        chk("async_we", bus.we, 0);
        chk("async_busy", busy, 0);
        chk("async_rdata", cpu_rdata, 0);
        @(negedge clk); reset_n = 1;
        last_rdata = '0;
        run_txn(1, 0, 0, 16'o006000, 16'h0, 16'h7777, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
